// File: rtl/mem_miss_arbiter.sv
// Arbitrates the shared main-memory refill port between icache and dcache misses.
// One transaction in flight at a time, round-robin on ties, with a response timeout.
module mem_miss_arbiter #(
  parameter int ADDR_W         = 20,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ic_req_valid,
  input  logic [ADDR_W+LINE_W:0]   ic_req_info,
  output logic                     ic_rsp_valid,
  output logic [LINE_W-1:0]        ic_rsp_data,
  output logic                     ic_rsp_bus_error,
  input  logic                     dc_req_valid,
  input  logic [ADDR_W+LINE_W:0]   dc_req_info,
  output logic                     dc_rsp_valid,
  output logic [LINE_W-1:0]        dc_rsp_data,
  output logic                     dc_rsp_bus_error,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W+LINE_W:0]   mem_req_info,
  input  logic                     mem_rsp_valid,
  input  logic [LINE_W-1:0]        mem_rsp_data,
  input  logic                     mem_rsp_bus_error,
  output logic                     arb_busy
);

  localparam int INFO_W = ADDR_W + LINE_W + 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  typedef enum logic {ICACHE, DCACHE} src_t;

  state_t            state;
  src_t              grant;
  src_t              last_grant;
  src_t              pick;
  logic              pend_ic;
  logic              pend_dc;
  logic [INFO_W-1:0] buf_ic;
  logic [INFO_W-1:0] buf_dc;
  logic [CNT_W-1:0]  wait_cnt;
  logic              rsp_done;
  logic              time_done;
  logic              complete;

  // A real response in the final wait cycle takes precedence over the timeout.
  assign rsp_done  = (state == WAIT_RSP) && mem_rsp_valid;
  assign time_done = (state == WAIT_RSP) && !mem_rsp_valid &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign complete  = rsp_done || time_done;
  assign arb_busy  = (state != IDLE);

  always_comb begin
    pick = ICACHE;
    if (pend_ic && pend_dc) begin
      if (last_grant == ICACHE) pick = DCACHE;
      else                      pick = ICACHE;
    end else if (pend_dc) begin
      pick = DCACHE;
    end
  end

  // One-entry miss buffers; a pulse while already pending is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_ic <= 1'b0;
      pend_dc <= 1'b0;
      buf_ic  <= '0;
      buf_dc  <= '0;
    end else begin
      if (complete && grant == ICACHE) begin
        pend_ic <= 1'b0;
      end else if (ic_req_valid && !pend_ic) begin
        pend_ic <= 1'b1;
        buf_ic  <= ic_req_info;
      end
      if (complete && grant == DCACHE) begin
        pend_dc <= 1'b0;
      end else if (dc_req_valid && !pend_dc) begin
        pend_dc <= 1'b1;
        buf_dc  <= dc_req_info;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      grant            <= ICACHE;
      last_grant       <= ICACHE;
      wait_cnt         <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_info     <= '0;
      ic_rsp_valid     <= 1'b0;
      ic_rsp_data      <= '0;
      ic_rsp_bus_error <= 1'b0;
      dc_rsp_valid     <= 1'b0;
      dc_rsp_data      <= '0;
      dc_rsp_bus_error <= 1'b0;
    end else begin
      ic_rsp_valid     <= 1'b0;
      ic_rsp_data      <= '0;
      ic_rsp_bus_error <= 1'b0;
      dc_rsp_valid     <= 1'b0;
      dc_rsp_data      <= '0;
      dc_rsp_bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_ic || pend_dc) begin
            grant         <= pick;
            mem_req_valid <= 1'b1;
            mem_req_info  <= (pick == DCACHE) ? buf_dc : buf_ic;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_info  <= '0;
            wait_cnt      <= '0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (complete) begin
            if (grant == DCACHE) begin
              dc_rsp_valid     <= 1'b1;
              dc_rsp_data      <= rsp_done ? mem_rsp_data : '0;
              dc_rsp_bus_error <= rsp_done ? mem_rsp_bus_error : 1'b1;
            end else begin
              ic_rsp_valid     <= 1'b1;
              ic_rsp_data      <= rsp_done ? mem_rsp_data : '0;
              ic_rsp_bus_error <= rsp_done ? mem_rsp_bus_error : 1'b1;
            end
            last_grant <= grant;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Self-checking bench for mem_miss_arbiter: directed vector table, corner-case
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_miss_arbiter;

  localparam int TMO = 8;
  localparam logic [127:0] FILL = {16{8'hA5}};

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ic_req_valid = 1'b0;
  logic [148:0] ic_req_info = '0;
  logic         ic_rsp_valid;
  logic [127:0] ic_rsp_data;
  logic         ic_rsp_bus_error;
  logic         dc_req_valid = 1'b0;
  logic [148:0] dc_req_info = '0;
  logic         dc_rsp_valid;
  logic [127:0] dc_rsp_data;
  logic         dc_rsp_bus_error;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [148:0] mem_req_info;
  logic         mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = '0;
  logic         mem_rsp_bus_error = 1'b0;
  logic         arb_busy;

  mem_miss_arbiter #(.ADDR_W(20), .LINE_W(128), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_info(ic_req_info),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_bus_error(ic_rsp_bus_error),
    .dc_req_valid(dc_req_valid), .dc_req_info(dc_req_info),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_bus_error(dc_rsp_bus_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_info(mem_req_info),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error),
    .arb_busy(arb_busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // drv = {ic_v, dc_v, ready, rsp_v, rsp_err}; expect = {mem_v, ic_v, ic_err, dc_v, dc_err, busy}
  typedef struct {
    logic [4:0]  drv;
    logic [19:0] addr;
    logic [5:0]  expect_bits;
    logic [19:0] exp_addr;
  } vec_t;

  vec_t vecs[16];

  // Reference model: pending slots plus one in-flight transaction (0 = icache, 1 = dcache)
  bit           m_pend[2];
  logic [148:0] m_info[2];
  int           m_last;
  int           tx_owner;
  bit           tx_accepted;
  int           tx_waited;
  logic         e_rsp_v[2];
  logic [127:0] e_rsp_d[2];
  logic         e_rsp_e[2];

  function automatic logic [148:0] make_info(input logic [19:0] addr, input logic st);
    return {addr, st, 108'(0), addr};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [148:0] act, input logic [148:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic icv, input logic [148:0] ici, input logic dcv,
                                input logic [148:0] dci, input logic rdy, input logic rv,
                                input logic [127:0] rd, input logic re);
    ic_req_valid      = icv;
    ic_req_info       = ici;
    dc_req_valid      = dcv;
    dc_req_info       = dci;
    mem_req_ready     = rdy;
    mem_rsp_valid     = rv;
    mem_rsp_data      = rd;
    mem_rsp_bus_error = re;
  endtask

  task automatic quiet();
    apply_stimulus('0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    quiet();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_for_mem(input string name);
    int n;
    n = 0;
    while (!mem_req_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (!mem_req_valid) begin
      bad++;
      $display("[TB] FAIL %s wait: mem_req_valid=0 want 1 within 50 cycles", name);
    end
  endtask

  // Accept the issued request, wait one cycle, then return a response.
  task automatic serve(input logic [127:0] d, input logic e);
    apply_stimulus('0, '0, '0, '0, 1'b1, '0, '0, '0);
    @(negedge clock);
    quiet();
    @(negedge clock);
    apply_stimulus('0, '0, '0, '0, '0, 1'b1, d, e);
    @(negedge clock);
    quiet();
  endtask

  task automatic check_all_zero(input string name);
    check_bit({name, " mem_valid"}, mem_req_valid, 1'b0);
    check_vec({name, " mem_info"}, mem_req_info, '0);
    check_bit({name, " ic_valid"}, ic_rsp_valid, 1'b0);
    check_vec({name, " ic_data"}, 149'(ic_rsp_data), '0);
    check_bit({name, " ic_err"}, ic_rsp_bus_error, 1'b0);
    check_bit({name, " dc_valid"}, dc_rsp_valid, 1'b0);
    check_vec({name, " dc_data"}, 149'(dc_rsp_data), '0);
    check_bit({name, " dc_err"}, dc_rsp_bus_error, 1'b0);
    check_bit({name, " busy"}, arb_busy, 1'b0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_pend[s]  = 1'b0;
      m_info[s]  = '0;
      e_rsp_v[s] = 1'b0;
      e_rsp_d[s] = '0;
      e_rsp_e[s] = 1'b0;
    end
    m_last      = 0;
    tx_owner    = -1;
    tx_accepted = 1'b0;
    tx_waited   = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit           req[2];
    logic [148:0] inf[2];
    int           finished;
    finished = -1;
    req[0] = ic_req_valid;
    req[1] = dc_req_valid;
    inf[0] = ic_req_info;
    inf[1] = dc_req_info;
    for (int s = 0; s < 2; s++) begin
      e_rsp_v[s] = 1'b0;
      e_rsp_d[s] = '0;
      e_rsp_e[s] = 1'b0;
    end
    if (tx_owner < 0) begin
      if (m_pend[0] || m_pend[1]) begin
        if (m_pend[0] && m_pend[1]) tx_owner = 1 - m_last;
        else                        tx_owner = m_pend[1] ? 1 : 0;
        tx_accepted = 1'b0;
      end
    end else if (!tx_accepted) begin
      if (mem_req_ready) begin
        tx_accepted = 1'b1;
        tx_waited   = 0;
      end
    end else if (mem_rsp_valid) begin
      e_rsp_v[tx_owner] = 1'b1;
      e_rsp_d[tx_owner] = mem_rsp_data;
      e_rsp_e[tx_owner] = mem_rsp_bus_error;
      finished = tx_owner;
    end else if (tx_waited == TMO - 1) begin
      e_rsp_v[tx_owner] = 1'b1;
      e_rsp_e[tx_owner] = 1'b1;
      finished = tx_owner;
    end else begin
      tx_waited++;
    end
    for (int s = 0; s < 2; s++) begin
      if (finished == s) begin
        m_pend[s] = 1'b0;
      end else if (req[s] && !m_pend[s]) begin
        m_pend[s] = 1'b1;
        m_info[s] = inf[s];
      end
    end
    if (finished >= 0) begin
      m_last   = finished;
      tx_owner = -1;
    end
  endtask

  task automatic check_output(input int cyc);
    logic         exp_mem_v;
    logic [148:0] exp_mem_i;
    exp_mem_v = (tx_owner >= 0) && !tx_accepted;
    exp_mem_i = exp_mem_v ? m_info[tx_owner] : '0;
    check_bit($sformatf("rnd%0d mem_valid", cyc), mem_req_valid, exp_mem_v);
    check_vec($sformatf("rnd%0d mem_info", cyc), mem_req_info, exp_mem_i);
    check_bit($sformatf("rnd%0d ic_valid", cyc), ic_rsp_valid, e_rsp_v[0]);
    check_vec($sformatf("rnd%0d ic_data", cyc), 149'(ic_rsp_data), 149'(e_rsp_d[0]));
    check_bit($sformatf("rnd%0d ic_err", cyc), ic_rsp_bus_error, e_rsp_e[0]);
    check_bit($sformatf("rnd%0d dc_valid", cyc), dc_rsp_valid, e_rsp_v[1]);
    check_vec($sformatf("rnd%0d dc_data", cyc), 149'(dc_rsp_data), 149'(e_rsp_d[1]));
    check_bit($sformatf("rnd%0d dc_err", cyc), dc_rsp_bus_error, e_rsp_e[1]);
    check_bit($sformatf("rnd%0d busy", cyc), arb_busy, tx_owner >= 0);
  endtask

  initial begin
    int           n;
    logic [148:0] held;
    logic [148:0] rinfo_ic;
    logic [148:0] rinfo_dc;
    logic [127:0] rdata;

    vecs[0]  = '{5'b10000, 20'h01234, 6'b000000, 20'h00000};
    vecs[1]  = '{5'b00000, 20'h00000, 6'b100001, 20'h01234};
    vecs[2]  = '{5'b00100, 20'h00000, 6'b000001, 20'h00000};
    vecs[3]  = '{5'b00000, 20'h00000, 6'b000001, 20'h00000};
    vecs[4]  = '{5'b00000, 20'h00000, 6'b000001, 20'h00000};
    vecs[5]  = '{5'b00010, 20'h00000, 6'b010000, 20'h00000};
    vecs[6]  = '{5'b00000, 20'h00000, 6'b000000, 20'h00000};
    vecs[7]  = '{5'b10000, 20'h00777, 6'b000000, 20'h00000};
    vecs[8]  = '{5'b00000, 20'h00000, 6'b100001, 20'h00777};
    vecs[9]  = '{5'b00100, 20'h00000, 6'b000001, 20'h00000};
    vecs[10] = '{5'b00011, 20'h00000, 6'b011000, 20'h00000};
    vecs[11] = '{5'b10000, 20'h00888, 6'b000000, 20'h00000};
    vecs[12] = '{5'b00000, 20'h00000, 6'b100001, 20'h00888};
    vecs[13] = '{5'b00100, 20'h00000, 6'b000001, 20'h00000};
    vecs[14] = '{5'b00010, 20'h00000, 6'b010000, 20'h00000};
    vecs[15] = '{5'b00000, 20'h00000, 6'b000000, 20'h00000};

    quiet();
    @(negedge clock);
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].drv[4], make_info(vecs[i].addr, 1'b0), vecs[i].drv[3],
                     make_info(vecs[i].addr, 1'b0), vecs[i].drv[2], vecs[i].drv[1],
                     FILL, vecs[i].drv[0]);
      @(negedge clock);
      check_bit($sformatf("vec%0d mem_valid", i), mem_req_valid, vecs[i].expect_bits[5]);
      check_vec($sformatf("vec%0d mem_info", i), mem_req_info,
                vecs[i].expect_bits[5] ? make_info(vecs[i].exp_addr, 1'b0) : '0);
      check_bit($sformatf("vec%0d ic_valid", i), ic_rsp_valid, vecs[i].expect_bits[4]);
      check_vec($sformatf("vec%0d ic_data", i), 149'(ic_rsp_data),
                vecs[i].expect_bits[4] ? 149'(FILL) : '0);
      check_bit($sformatf("vec%0d ic_err", i), ic_rsp_bus_error, vecs[i].expect_bits[3]);
      check_bit($sformatf("vec%0d dc_valid", i), dc_rsp_valid, vecs[i].expect_bits[2]);
      check_bit($sformatf("vec%0d dc_err", i), dc_rsp_bus_error, vecs[i].expect_bits[1]);
      check_bit($sformatf("vec%0d busy", i), arb_busy, vecs[i].expect_bits[0]);
    end

    // Request held off by the memory for five cycles must stay stable.
    apply_stimulus(1'b1, make_info(20'h03C3C, 1'b1), '0, '0, '0, '0, '0, '0);
    @(negedge clock);
    quiet();
    wait_for_mem("stall");
    held = make_info(20'h03C3C, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check_bit($sformatf("stall%0d mem_valid", k), mem_req_valid, 1'b1);
      check_vec($sformatf("stall%0d mem_info", k), mem_req_info, held);
      @(negedge clock);
    end
    apply_stimulus('0, '0, '0, '0, 1'b1, '0, '0, '0);
    @(negedge clock);
    quiet();
    check_bit("stall accepted mem_valid", mem_req_valid, 1'b0);
    check_bit("stall accepted busy", arb_busy, 1'b1);
    apply_stimulus('0, '0, '0, '0, '0, 1'b1, 128'h5, '0);
    @(negedge clock);
    quiet();
    check_bit("stall store ack", ic_rsp_valid, 1'b1);
    check_vec("stall store data", 149'(ic_rsp_data), 149'(128'h5));

    // Timeout on a dcache refill, then a late response that must be ignored.
    apply_stimulus('0, '0, 1'b1, make_info(20'h0DEAD, 1'b0), '0, '0, '0, '0);
    @(negedge clock);
    quiet();
    wait_for_mem("timeout");
    apply_stimulus('0, '0, '0, '0, 1'b1, '0, '0, '0);
    n = 0;
    do begin
      @(negedge clock);
      quiet();
      n++;
    end while (!dc_rsp_valid && n < 20);
    check_vec("timeout latency", 149'(n), 149'(9));
    check_bit("timeout dc_err", dc_rsp_bus_error, 1'b1);
    check_vec("timeout dc_data", 149'(dc_rsp_data), '0);
    check_bit("timeout ic_valid", ic_rsp_valid, 1'b0);
    apply_stimulus('0, '0, '0, '0, '0, 1'b1, FILL, '0);
    @(negedge clock);
    quiet();
    check_bit("late rsp dc_valid", dc_rsp_valid, 1'b0);
    check_bit("late rsp ic_valid", ic_rsp_valid, 1'b0);
    check_bit("late rsp busy", arb_busy, 1'b0);

    // Simultaneous misses: dcache wins first after reset, icache follows back-to-back.
    do_reset();
    apply_stimulus(1'b1, make_info(20'h0AAAA, 1'b0), 1'b1, make_info(20'h0BBBB, 1'b1),
                   '0, '0, '0, '0);
    @(negedge clock);
    quiet();
    @(negedge clock);
    check_bit("tie1 mem_valid", mem_req_valid, 1'b1);
    check_vec("tie1 dc first", mem_req_info, make_info(20'h0BBBB, 1'b1));
    serve(128'h1111, 1'b0);
    check_bit("tie1 dc rsp", dc_rsp_valid, 1'b1);
    check_vec("tie1 dc data", 149'(dc_rsp_data), 149'(128'h1111));
    check_bit("tie1 ic quiet", ic_rsp_valid, 1'b0);
    @(negedge clock);
    check_bit("tie1 b2b mem_valid", mem_req_valid, 1'b1);
    check_vec("tie1 ic second", mem_req_info, make_info(20'h0AAAA, 1'b0));
    serve(128'h2222, 1'b0);
    check_bit("tie1 ic rsp", ic_rsp_valid, 1'b1);
    apply_stimulus('0, '0, 1'b1, make_info(20'h0CCCC, 1'b0), '0, '0, '0, '0);
    @(negedge clock);
    quiet();
    wait_for_mem("dc solo");
    serve(128'h3333, 1'b0);
    check_bit("dc solo rsp", dc_rsp_valid, 1'b1);
    apply_stimulus(1'b1, make_info(20'h0AAA1, 1'b0), 1'b1, make_info(20'h0BBB1, 1'b0),
                   '0, '0, '0, '0);
    @(negedge clock);
    quiet();
    @(negedge clock);
    check_vec("tie2 ic first", mem_req_info, make_info(20'h0AAA1, 1'b0));
    serve(128'h4444, 1'b0);
    check_bit("tie2 ic rsp", ic_rsp_valid, 1'b1);
    @(negedge clock);
    check_vec("tie2 dc second", mem_req_info, make_info(20'h0BBB1, 1'b0));
    serve(128'h5555, 1'b0);
    check_bit("tie2 dc rsp", dc_rsp_valid, 1'b1);

    // Asynchronous reset while waiting on memory with the dcache also pending.
    apply_stimulus(1'b1, make_info(20'h01111, 1'b0), '0, '0, '0, '0, '0, '0);
    @(negedge clock);
    quiet();
    wait_for_mem("rst seq");
    apply_stimulus('0, '0, 1'b1, make_info(20'h02222, 1'b0), 1'b1, '0, '0, '0);
    @(negedge clock);
    quiet();
    check_bit("rst seq busy before", arb_busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_bit($sformatf("post reset%0d mem_valid", k), mem_req_valid, 1'b0);
      check_bit($sformatf("post reset%0d busy", k), arb_busy, 1'b0);
    end

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check_output(cyc);
      rinfo_ic = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rinfo_dc = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rdata    = {$urandom(), $urandom(), $urandom(), $urandom()};
      apply_stimulus($urandom_range(0, 3) == 0, rinfo_ic, $urandom_range(0, 3) == 0, rinfo_dc,
                     1'($urandom_range(0, 1)), $urandom_range(0, 9) < 2, rdata,
                     1'($urandom_range(0, 1)));
      model_step();
      @(negedge clock);
    end
    check_output(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
